// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared ALU op codes and HI/LO sequencer state encoding
// Purpose: CtrlALUOp codes shared with mips_cpu_control, plus the HI/LO FSM state type.
// Ports: none (package).
package mips_cpu_pkg;

   localparam logic [4:0] ALU_MUL  = 5'd2;
   localparam logic [4:0] ALU_DIV  = 5'd3;
   localparam logic [4:0] ALU_MULU = 5'd22;
   localparam logic [4:0] ALU_DIVU = 5'd23;
   localparam logic [4:0] ALU_MTHI = 5'd24;
   localparam logic [4:0] ALU_MTLO = 5'd25;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL      = 2'd1,
      ST_DIV_STEP = 2'd2,
      ST_DIV_FIX  = 2'd3
   } hilo_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// rtl/mips_cpu_div_step.sv - combinational restoring-divide step, BITS quotient bits per call
// Purpose: one sequencer cycle of unsigned restoring division. The dividend enters in quot_i
//          and shifts out MSB-first into the partial remainder while quotient bits shift in.
// Ports:
//   rem_i     in  32  partial remainder
//   quot_i    in  32  remaining dividend bits / quotient bits so far
//   divisor_i in  32  unsigned divisor
//   rem_o     out 32  updated partial remainder
//   quot_o    out 32  updated quotient/dividend register
module mips_cpu_div_step #(
   parameter int BITS = 1
) (
   input  logic [31:0] rem_i,
   input  logic [31:0] quot_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic [31:0] quot_o
);

   logic [31:0] r;
   logic [31:0] q;
   logic [32:0] sh;
   logic [32:0] diff;

   always_comb begin
      r    = rem_i;
      q    = quot_i;
      sh   = '0;
      diff = '0;
      for (int i = 0; i < BITS; i++) begin
         sh   = {r, q[31]};
         q    = {q[30:0], 1'b0};
         diff = sh - {1'b0, divisor_i};
         // diff[32] is the borrow; without it the result is below divisor so it fits 32 bits
         if (!diff[32]) begin
            r    = diff[31:0];
            q[0] = 1'b1;
         end else begin
            r = sh[31:0];
         end
      end
      rem_o  = r;
      quot_o = q;
   end

endmodule

// File: rtl/mips_cpu_hilo_sequencer.sv
// rtl/mips_cpu_hilo_sequencer.sv - multi-cycle MULT/DIV/MTHI/MTLO sequencer owning HI/LO
// Purpose: executes HI/LO ops from the decoder, holds HI/LO, stalls dependent ops while busy.
// Ports:
//   clk_i        in   1   system clock
//   reset_i      in   1   synchronous active-high reset
//   op_valid_i   in   1   instruction in execute is valid
//   spc_wr_en_i  in   1   CtrlSpcRegWriteEn
//   alu_op_i     in   5   CtrlALUOp
//   rs_data_i    in  32   operand A
//   rt_data_i    in  32   operand B
//   mf_req_i     in   1   MFHI/MFLO in execute
//   stall_o      out  1   hold current instruction (combinational)
//   busy_o       out  1   MUL/DIV in flight
//   hi_o, lo_o   out 32   HI/LO registers
module mips_cpu_hilo_sequencer
   import mips_cpu_pkg::*;
#(
   parameter int MUL_CYCLES         = 4,
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        op_valid_i,
   input  logic        spc_wr_en_i,
   input  logic [4:0]  alu_op_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   input  logic        mf_req_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES - 1);
   localparam logic [4:0] DIV_CNT = 5'(32 / DIV_BITS_PER_CYCLE - 1);

   hilo_state_t state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;       // multiplicand, or |dividend| turning into quotient
   logic [31:0] b_q, b_d;       // multiplier, or |divisor|
   logic [31:0] rem_q, rem_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        sgn_q, sgn_d;   // MULT (signed) vs MULTU
   logic        qneg_q, qneg_d; // DIV quotient must be negated
   logic        rneg_q, rneg_d; // DIV remainder takes negative dividend sign

   logic        accept;
   logic        is_signed_op;
   logic [63:0] a_ext, b_ext, product;
   logic [31:0] step_rem, step_quot;

   mips_cpu_div_step #(.BITS(DIV_BITS_PER_CYCLE)) u_div_step (
      .rem_i     (rem_q),
      .quot_i    (a_q),
      .divisor_i (b_q),
      .rem_o     (step_rem),
      .quot_o    (step_quot)
   );

   assign accept       = op_valid_i & spc_wr_en_i & ~busy_q;
   assign is_signed_op = (alu_op_i == ALU_MUL) || (alu_op_i == ALU_DIV);

   // Low 64 bits of a 64x64 product of extended operands equal the signed/unsigned 32x32 product.
   assign a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
   assign b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
   assign product = a_ext * b_ext;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (alu_op_i)
                  ALU_MTHI: hi_d = rs_data_i;
                  ALU_MTLO: lo_d = rs_data_i;
                  ALU_MUL, ALU_MULU: begin
                     a_d     = rs_data_i;
                     b_d     = rt_data_i;
                     sgn_d   = is_signed_op;
                     cnt_d   = MUL_CNT;
                     busy_d  = 1'b1;
                     state_d = ST_MUL;
                  end
                  ALU_DIV, ALU_DIVU: begin
                     a_d     = (is_signed_op && rs_data_i[31]) ? -rs_data_i : rs_data_i;
                     b_d     = (is_signed_op && rt_data_i[31]) ? -rt_data_i : rt_data_i;
                     qneg_d  = is_signed_op && (rs_data_i[31] ^ rt_data_i[31]);
                     rneg_d  = is_signed_op && rs_data_i[31];
                     rem_d   = '0;
                     cnt_d   = DIV_CNT;
                     busy_d  = 1'b1;
                     state_d = ST_DIV_STEP;
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (cnt_q == 5'd0) begin
               {hi_d, lo_d} = product;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         ST_DIV_STEP: begin
            a_d   = step_quot;
            rem_d = step_rem;
            if (cnt_q == 5'd0) state_d = ST_DIV_FIX;
            else               cnt_d   = cnt_q - 5'd1;
         end
         ST_DIV_FIX: begin
            // Divide by zero leaves rem = |dividend|, so sign fix-up restores the raw dividend in HI.
            if (b_q == 32'd0) lo_d = 32'hFFFF_FFFF;
            else              lo_d = qneg_q ? -a_q : a_q;
            hi_d    = rneg_q ? -rem_q : rem_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign stall_o = busy_q & ((op_valid_i & spc_wr_en_i) | mf_req_i);
   assign busy_o  = busy_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_sequencer.sv
// tb/tb_mips_cpu_hilo_sequencer.sv - directed-vector bench for the HI/LO sequencer
module tb_mips_cpu_hilo_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        spc_wr_en;
   logic [4:0]  alu_op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mf_req;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec  = 0;
   int n_miss = 0;

   mips_cpu_hilo_sequencer dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .op_valid_i  (op_valid),
      .spc_wr_en_i (spc_wr_en),
      .alu_op_i    (alu_op),
      .rs_data_i   (rs_data),
      .rt_data_i   (rt_data),
      .mf_req_i    (mf_req),
      .stall_o     (stall),
      .busy_o      (busy),
      .hi_o        (hi),
      .lo_o        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one op for exactly one accept edge; returns 1ns after that edge.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_valid  = 1'b1;
      spc_wr_en = 1'b1;
      alu_op    = op;
      rs_data   = a;
      rt_data   = b;
      @(posedge clk);
      #1;
      op_valid  = 1'b0;
      spc_wr_en = 1'b0;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Run a MUL/DIV and check hi/lo stay put until exactly `lat` edges after accept.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] old_hi, old_lo;
      old_hi = hi;
      old_lo = lo;
      issue(op, a, b);
      edges(lat - 1);
      chk({tag, " busy_pre"}, {31'd0, busy}, 32'd1);
      chk({tag, " lo_pre"}, lo, old_lo);
      chk({tag, " hi_pre"}, hi, old_hi);
      edges(1);
      chk({tag, " busy_post"}, {31'd0, busy}, 32'd0);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      int stalled;
      int unstalled;
      reset     = 1'b1;
      op_valid  = 1'b0;
      spc_wr_en = 1'b0;
      alu_op    = 5'd0;
      rs_data   = '0;
      rt_data   = '0;
      mf_req    = 1'b0;
      edges(2);
      reset = 1'b0;
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst stall", {31'd0, stall}, 32'd0);

      // MTHI then MFHI next cycle
      @(negedge clk);
      op_valid = 1'b1; spc_wr_en = 1'b1; alu_op = 5'd24; rs_data = 32'h1234_5678;
      #1 chk("mthi stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      op_valid = 1'b0; spc_wr_en = 1'b0; mf_req = 1'b1;
      #1;
      chk("mthi hi", hi, 32'h1234_5678);
      chk("mfhi stall", {31'd0, stall}, 32'd0);
      chk("mthi busy", {31'd0, busy}, 32'd0);
      mf_req = 1'b0;
      issue(5'd25, 32'hCAFE_0001, 32'd0);
      chk("mtlo lo", lo, 32'hCAFE_0001);
      chk("mtlo hi kept", hi, 32'h1234_5678);

      // Unknown code with spc_wr_en is ignored
      issue(5'd5, 32'hDEAD_BEEF, 32'd1);
      edges(1);
      chk("bad op busy", {31'd0, busy}, 32'd0);
      chk("bad op hi", hi, 32'h1234_5678);
      chk("bad op lo", lo, 32'hCAFE_0001);

      run_op("mult",  5'd2,  32'hFFFF_FFFE, 32'd3, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 5'd22, 32'hFFFF_FFFE, 32'd3, 4, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("mult big", 5'd2, 32'h8000_0000, 32'h8000_0000, 4, 32'h4000_0000, 32'h0000_0000);
      run_op("div -7/2", 5'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 100/7", 5'd23, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("div 5/0", 5'd3, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);
      run_op("div -5/0", 5'd3, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_op("div min/-1", 5'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
      run_op("div 7/-2", 5'd3, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
      run_op("divu big", 5'd23, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, 32'h0FFF_FFFF);

      // MFLO issued 3 cycles into a DIVU: stalled until busy falls
      issue(5'd23, 32'd1000, 32'd10);
      edges(3);
      mf_req    = 1'b1;
      stalled   = 0;
      unstalled = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (!busy) break;
         stalled++;
         if (!stall) unstalled++;
         edges(1);
      end
      chk("mflo stall cycles", stalled, 30);
      chk("mflo stall gaps", unstalled, 0);
      chk("mflo stall released", {31'd0, stall}, 32'd0);
      chk("mflo value", lo, 32'd100);
      mf_req = 1'b0;

      // MTLO held while busy, accepted the cycle after busy falls
      issue(5'd23, 32'd50, 32'd5);
      op_valid = 1'b1; spc_wr_en = 1'b1; alu_op = 5'd25; rs_data = 32'h0000_ABCD;
      #1 chk("mtlo busy stall", {31'd0, stall}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         edges(1);
      end
      chk("mtlo wait stall", {31'd0, stall}, 32'd0);
      chk("mtlo wait lo", lo, 32'd10);
      chk("mtlo wait hi", hi, 32'd0);
      edges(1);
      op_valid = 1'b0; spc_wr_en = 1'b0;
      chk("mtlo late lo", lo, 32'h0000_ABCD);
      chk("mtlo late busy", {31'd0, busy}, 32'd0);

      // Reset mid-DIV aborts, then a fresh MULT works
      issue(5'd3, 32'd77, 32'd7);
      edges(9);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      edges(40);
      chk("abort no late write", lo, 32'd0);
      run_op("mult after rst", 5'd2, 32'd6, 32'hFFFF_FFF9, 4, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
